sliced_alu: RTL
===============

# sliced_alu

Parametrised multi-cycle accumulator ALU and successor to the single-cycle 8-bit ALU in the CPU datapath. It holds a WIDTH-bit accumulator A and a 4-bit flag register F (Z N H C). It runs the eight SM83 arithmetic/logic operations on operands wider than the datapath by processing them in SLICE-bit beats, least-significant slice first, with a carry chain between beats. It serves 16-bit operations such as ADD HL,rr with SM83-correct flags, and uses a start/busy/done handshake toward the CPU control unit.

## Interface
- WIDTH, 16, accumulator and operand width; must be a multiple of SLICE
- SLICE, 8, bits processed per beat; must be at least 4. BEATS = WIDTH/SLICE
- i_Clk  in  1  system clock; all state changes on its rising edge
- i_Reset  in  1  reset, synchronous and active-high; overrides i_Enable
- i_Enable  in  1  clock enable; when low, all state holds, including o_Done
- i_Start  in  1  operation request
- i_Op  in  3  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- i_Operand  in  WIDTH  B operand, sampled at start
- i_Save_Flags  in  1  sampled at start; 1 commits the result flags to F
- i_Write_A  in  1  direct load of A from i_Data
- i_Write_F  in  1  direct load of F from i_Flags
- i_Data  in  WIDTH  direct-load data for A
- i_Flags  in  4  direct-load data for F, {Z,N,H,C}
- o_A  out  WIDTH  accumulator contents
- o_F  out  4  flag register {Z,N,H,C}
- o_Result  out  WIDTH  result of the last completed operation, including CP
- o_Busy  out  1  high while an operation is in progress
- o_Done  out  1  one-cycle completion pulse

## Operation
- **FSM states:** IDLE and RUN. A beat counter runs 0..BEATS-1.
- **IDLE → RUN:** taken on an enabled edge with i_Start=1.
  - Capture A, i_Operand, i_Op and i_Save_Flags into working registers.
  - Carry-in = F.C for ADC/SBC; 0 otherwise.
- **RUN, each enabled edge:** compute slice [beat*SLICE +: SLICE] and store it in an internal result register. Propagate carry/borrow-out to the next beat.
- **Last beat (beat = BEATS-1):** on this edge, in the same cycle:
  - load o_Result;
  - write A, except for CP;
  - write F if the captured i_Save_Flags=1;
  - set o_Done=1 for the next cycle;
  - return to IDLE.
- **Flag Z:** 1 if the full WIDTH-bit result is zero.
- **Flag N:** 1 for SUB, SBC and CP; 0 otherwise.
- **Flag H:**
  - ADD/ADC: carry out of bit 3 of the most-significant slice (bit 11 for 16/8).
  - SUB/SBC/CP: borrow from that same bit.
  - AND: 1. XOR/OR: 0.
- **Flag C:**
  - ADD/ADC: carry out of bit WIDTH-1.
  - SUB/SBC/CP: borrow out of bit WIDTH-1.
  - Logic ops: 0.
- **Arithmetic rules:**
  - Subtraction computes A − B − carry-in, modulo 2^WIDTH.
  - ADC/SBC use the carry-in in beat 0 only.
- **Direct loads:** i_Write_A and i_Write_F are honoured only in IDLE with i_Start=0. They are ignored while busy, and dropped if they coincide with i_Start.
- **Start while busy:** i_Start in RUN is ignored; no queuing.
- **Back-to-back starts:** a new i_Start is accepted in the o_Done cycle, since the FSM is already in IDLE.

## Timing
- **Reset values:** o_A=0, o_F=0, o_Result=0, o_Busy=0, o_Done=0. FSM goes to IDLE and the beat counter to 0.
- **Latency:** start accepted at edge t0. Beats execute at edges t1..tBEATS. A, F and o_Result update at edge tBEATS.
- **Busy window:** o_Busy is high during cycles t0+ through tBEATS−.
- **Done pulse:** o_Done is high for exactly one cycle, after edge tBEATS.
- **Single-beat case:** with BEATS=1 (SLICE=WIDTH), o_Busy is high for one cycle and o_Done follows.
- **Enable low:** i_Enable=0 stretches every phase. The beat counter, o_Busy and o_Done hold their values; o_Done stays high until the next enabled edge.
- **Reset mid-operation:** the operation is aborted on that edge with no commit and no o_Done. All outputs take their reset values.
- **o_Result stability:** o_Result and A never show partial results during RUN.

## Test plan
- **ADD, 16/8:** A=0x0FFF, ADD 0x0001, Save=1 → o_Busy high for 2 cycles. o_Done pulses one cycle after. A=0x1000, F=0b0010 (H only).
- **ADC carry chain:** A=0xFFFF, F.C=1, ADC 0x0000 → A=0x0000, F=0b1011 (Z, H, C).
- **CP:** A=0x1234, CP 0x1234 → A stays 0x1234, o_Result=0x0000, F=0b1100. Then SUB 0x1235 from 0x1234 → A=0xFFFF, F=0b0111.
- **Logic, flags not saved:** A=0x00F0, AND 0x0F0F with Save=0 → A=0x0000, F unchanged, o_Result=0x0000.
- **Handshake rules:**
  - i_Start asserted while busy is ignored.
  - i_Write_A while busy is ignored.
  - i_Enable held low for 3 cycles mid-RUN delays o_Done by exactly 3 cycles.
  - A start issued in the o_Done cycle is accepted.
- **Reset and single-beat:**
  - i_Reset asserted at edge t1 of ADD → A keeps no partial value, o_A=0, o_Done never pulses.
  - Re-run with WIDTH=8, SLICE=8: 0x3A+0xC6 → A=0x00, F=0b1011, done 1 cycle after start.

Source files
------------

// File: rtl/sliced_alu_if.sv
// Bus between the CPU control unit and sliced_alu: operation request,
// direct-load path and result/handshake outputs.
interface sliced_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_Enable;
    logic             i_Start;
    logic [2:0]       i_Op;
    logic [WIDTH-1:0] i_Operand;
    logic             i_Save_Flags;
    logic             i_Write_A;
    logic             i_Write_F;
    logic [WIDTH-1:0] i_Data;
    logic [3:0]       i_Flags;
    logic [WIDTH-1:0] o_A;
    logic [3:0]       o_F;
    logic [WIDTH-1:0] o_Result;
    logic             o_Busy;
    logic             o_Done;

    // Control unit side
    modport master (
        output i_Enable, i_Start, i_Op, i_Operand, i_Save_Flags,
        output i_Write_A, i_Write_F, i_Data, i_Flags,
        input  o_A, o_F, o_Result, o_Busy, o_Done
    );

    // ALU side
    modport slave (
        input  i_Enable, i_Start, i_Op, i_Operand, i_Save_Flags,
        input  i_Write_A, i_Write_F, i_Data, i_Flags,
        output o_A, o_F, o_Result, o_Busy, o_Done
    );
endinterface

// File: rtl/sliced_alu.sv
// Multi-cycle accumulator ALU: runs the eight SM83 ALU ops on WIDTH-bit
// operands in SLICE-bit beats, LS slice first, with a carry chain between
// beats. WIDTH must be a multiple of SLICE and SLICE must be at least 4.
module sliced_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 8
) (
    input logic         i_Clk,
    input logic         i_Reset,
    sliced_alu_if.slave bus_io
);
    localparam int unsigned      BEATS    = WIDTH / SLICE;
    localparam int unsigned      BeatW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpAdc = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpSbc = 3'd3;
    localparam logic [2:0] OpAnd = 3'd4;
    localparam logic [2:0] OpXor = 3'd5;
    localparam logic [2:0] OpOr  = 3'd6;
    localparam logic [2:0] OpCp  = 3'd7;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [3:0]       f_q, f_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    // Working copies captured at start
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       op_q, op_d;
    logic             save_q, save_d;
    logic             carry_q, carry_d;
    // Partial result, never visible outside until the last beat
    logic [WIDTH-1:0] work_q, work_d;

    logic [31:0]      base;
    logic [SLICE-1:0] a_sl, b_sl, sl_res;
    logic [SLICE:0]   sum, diff;
    logic [4:0]       nib_sum, nib_diff;
    logic             sl_c, sl_h, is_sub;
    logic [WIDTH-1:0] res_full;

    // Slice datapath for the current beat; H comes from bit 3 of the slice,
    // which is only committed on the MS beat.
    always_comb begin
        base     = 32'(beat_q) * SLICE;
        a_sl     = opa_q[base +: SLICE];
        b_sl     = opb_q[base +: SLICE];
        is_sub   = (op_q == OpSub) || (op_q == OpSbc) || (op_q == OpCp);
        sum      = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        diff     = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, carry_q};
        nib_sum  = {1'b0, a_sl[3:0]} + {1'b0, b_sl[3:0]} + {4'b0, carry_q};
        nib_diff = {1'b0, a_sl[3:0]} - {1'b0, b_sl[3:0]} - {4'b0, carry_q};
        sl_res   = '0;
        sl_c     = 1'b0;
        sl_h     = 1'b0;
        case (op_q)
            OpAdd, OpAdc: begin
                sl_res = sum[SLICE-1:0];
                sl_c   = sum[SLICE];
                sl_h   = nib_sum[4];
            end
            OpSub, OpSbc, OpCp: begin
                sl_res = diff[SLICE-1:0];
                sl_c   = diff[SLICE];
                sl_h   = nib_diff[4];
            end
            OpAnd: begin
                sl_res = a_sl & b_sl;
                sl_h   = 1'b1;
            end
            OpXor:   sl_res = a_sl ^ b_sl;
            default: sl_res = a_sl | b_sl;
        endcase
        res_full                = work_q;
        res_full[base +: SLICE] = sl_res;
    end

    // Next-state logic: start capture, beat sequencing, commit on last beat
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        a_d      = a_q;
        f_d      = f_q;
        result_d = result_q;
        done_d   = done_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        save_d   = save_q;
        carry_d  = carry_q;
        work_d   = work_q;
        if (bus_io.i_Enable) begin
            done_d = 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.i_Start) begin
                        state_d = StRun;
                        beat_d  = '0;
                        opa_d   = a_q;
                        opb_d   = bus_io.i_Operand;
                        op_d    = bus_io.i_Op;
                        save_d  = bus_io.i_Save_Flags;
                        carry_d = ((bus_io.i_Op == OpAdc) || (bus_io.i_Op == OpSbc)) ? f_q[0]
                                                                                     : 1'b0;
                        work_d  = '0;
                    end else begin
                        // Direct loads only when nothing is being started
                        if (bus_io.i_Write_A) a_d = bus_io.i_Data;
                        if (bus_io.i_Write_F) f_d = bus_io.i_Flags;
                    end
                end
                default: begin
                    work_d  = res_full;
                    carry_d = sl_c;
                    if (beat_q == LastBeat) begin
                        result_d = res_full;
                        if (op_q != OpCp) a_d = res_full;
                        if (save_q) f_d = {(res_full == '0), is_sub, sl_h, sl_c};
                        done_d  = 1'b1;
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // State register with synchronous reset; reset aborts any operation
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            a_q      <= '0;
            f_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            save_q   <= 1'b0;
            carry_q  <= 1'b0;
            work_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            a_q      <= a_d;
            f_q      <= f_d;
            result_q <= result_d;
            done_q   <= done_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            save_q   <= save_d;
            carry_q  <= carry_d;
            work_q   <= work_d;
        end
    end

    assign bus_io.o_A      = a_q;
    assign bus_io.o_F      = f_q;
    assign bus_io.o_Result = result_q;
    assign bus_io.o_Busy   = (state_q == StRun);
    assign bus_io.o_Done   = done_q;
endmodule
